// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding,
// oversampling ratio and parity mode codes.
package uart_pkg;

   localparam int OS = 16;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a first-word-fall-through FIFO and
// serializes start, data (LSB first), optional parity and stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            fifo_empty,
   input  logic [DBIT-1:0] fifo_data,
   output logic            fifo_rd,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int              BW       = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [4:0]      OS_LAST  = 5'(OS - 1);
   localparam logic [4:0]      SB_LAST  = 5'(SB_TICK - 1);
   localparam logic [BW-1:0]   BIT_LAST = BW'(DBIT - 1);

   state_t          state, state_next;
   logic [4:0]      tick, tick_next;
   logic [BW-1:0]   nbit, nbit_next;
   logic [DBIT-1:0] shift, shift_next;
   logic            par, par_next;
   logic            tx_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         tick  <= '0;
         nbit  <= '0;
         shift <= '0;
         par   <= 1'b0;
         tx    <= 1'b1;
      end else begin
         state <= state_next;
         tick  <= tick_next;
         nbit  <= nbit_next;
         shift <= shift_next;
         par   <= par_next;
         tx    <= tx_next;
      end
   end

   always_comb begin
      state_next   = state;
      tick_next    = tick;
      nbit_next    = nbit;
      shift_next   = shift;
      par_next     = par;
      fifo_rd      = 1'b0;
      tx_done_tick = 1'b0;
      case (state)
         // A held reset must not pop a byte that would then be lost.
         ST_IDLE: begin
            if (!fifo_empty && !reset) begin
               fifo_rd    = 1'b1;
               state_next = ST_START;
               tick_next  = '0;
               shift_next = fifo_data;
               par_next   = ^fifo_data;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (tick == OS_LAST) begin
                  state_next = ST_DATA;
                  tick_next  = '0;
                  nbit_next  = '0;
               end else begin
                  tick_next = tick + 5'd1;
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (tick == OS_LAST) begin
                  tick_next  = '0;
                  shift_next = shift >> 1;
                  if (nbit == BIT_LAST)
                     state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  else
                     nbit_next = nbit + 1'b1;
               end else begin
                  tick_next = tick + 5'd1;
               end
            end
         end
         ST_PARITY: begin
            if (s_tick) begin
               if (tick == OS_LAST) begin
                  state_next = ST_STOP;
                  tick_next  = '0;
               end else begin
                  tick_next = tick + 5'd1;
               end
            end
         end
         ST_STOP: begin
            if (s_tick) begin
               if (tick == SB_LAST) begin
                  state_next   = ST_IDLE;
                  tick_next    = '0;
                  tx_done_tick = 1'b1;
               end else begin
                  tick_next = tick + 5'd1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // tx is derived from the next state so the line is registered and
   // moves on the very edge that enters each bit.
   always_comb begin
      case (state_next)
         ST_START:  tx_next = 1'b0;
         ST_DATA:   tx_next = shift_next[0];
         ST_PARITY: tx_next = (PARITY == PARITY_ODD) ? ~par : par;
         default:   tx_next = 1'b1;
      endcase
   end

   assign tx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants fed from FIFO models, frames
// checked bit by bit against a scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int N = 4;

   function automatic int par_of(input int i);
      return (i == 1) ? 1 : (i == 2) ? 2 : 0;
   endfunction

   function automatic int sb_of(input int i);
      return (i == 3) ? 32 : 16;
   endfunction

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic s_tick = 1'b0;
   logic [N-1:0]      fifo_empty, fifo_rd, tx, tx_busy, tx_done_tick;
   logic [N-1:0][7:0] fifo_data;

   logic [7:0] mem [N][16];
   int head [N] = '{default: 0};
   int tail [N] = '{default: 0};
   int pushed [N] = '{default: 0};
   int rd_cnt [N] = '{default: 0};
   int done_cnt [N] = '{default: 0};
   int done_exp [N] = '{default: 0};
   exp_t sb_q [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Baud tick model: one-clk pulse every second clock.
   always @(posedge clk) s_tick <= ~s_tick;

   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_tx #(.DBIT(8), .SB_TICK(sb_of(g)), .PARITY(par_of(g))) u_dut (
         .clk          (clk),
         .reset        (reset),
         .s_tick       (s_tick),
         .fifo_empty   (fifo_empty[g]),
         .fifo_data    (fifo_data[g]),
         .fifo_rd      (fifo_rd[g]),
         .tx           (tx[g]),
         .tx_busy      (tx_busy[g]),
         .tx_done_tick (tx_done_tick[g])
      );
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         fifo_empty[i] = (head[i] == tail[i]);
         fifo_data[i]  = mem[i][head[i] % 16];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (fifo_rd[i]) begin
            head[i]   <= head[i] + 1;
            rd_cnt[i] <= rd_cnt[i] + 1;
         end
         if (tx_done_tick[i]) done_cnt[i] <= done_cnt[i] + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input int i, input logic [7:0] d, input bit score);
      exp_t e;
      mem[i][tail[i] % 16] = d;
      tail[i]++;
      pushed[i]++;
      if (score) begin
         e.idx  = i;
         e.data = d;
         sb_q.push_back(e);
      end
   endtask

   // Waits for the next frame from the scoreboard head and checks every bit,
   // the start-bit length and the exact cycle of tx_done_tick.
   task automatic run_frame(input bit b2b);
      exp_t e;
      int i, p, a, n, nbits, t, done_n, target;
      bit early;
      logic [11:0] bits;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: no expected frame queued");
         return;
      end
      e = sb_q.pop_front();
      i = e.idx;
      p = par_of(i);
      bits = '0;
      bits[8:1] = e.data;
      nbits = (p != 0) ? 11 : 10;
      if (p == 1) bits[9] = ^e.data;
      if (p == 2) bits[9] = ~^e.data;
      bits[nbits-1] = 1'b1;
      t = 16 + 128 + ((p != 0) ? 16 : 0) + sb_of(i);

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx[i] !== 1'b0 && n < 300);
      if (b2b) check($sformatf("u%0d_b2b_gap", i), n, 1);
      check($sformatf("u%0d_start_seen", i), tx[i], 1'b0);
      if (tx[i] !== 1'b0) return;

      a = s_tick ? 1 : 2;
      n = 1;
      done_n = a + 2 * t - 2;
      early = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         target = a + 32 * k + 15;
         while (n < target) begin
            @(negedge clk);
            n++;
            if (tx_done_tick[i]) early = 1'b1;
            if (n == a + 30) check($sformatf("u%0d_start_len", i), tx[i], 1'b0);
         end
         check($sformatf("u%0d_%02h_bit%0d", i, e.data, k), tx[i], bits[k]);
      end
      while (n < done_n) begin
         @(negedge clk);
         n++;
         if (tx_done_tick[i] && n < done_n) early = 1'b1;
      end
      check($sformatf("u%0d_done_early", i), early, 1'b0);
      check($sformatf("u%0d_done_tick", i), tx_done_tick[i], 1'b1);
      check($sformatf("u%0d_busy_at_done", i), tx_busy[i], 1'b1);
      done_exp[i]++;
      @(negedge clk);
      check($sformatf("u%0d_busy_after", i), tx_busy[i], 1'b0);
      check($sformatf("u%0d_tx_idle", i), tx[i], 1'b1);
   endtask

   initial begin
      int a, n, bad_tx, bad_rd, bad_busy;

      // Reset state, then idle with empty FIFOs.
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 4'hF);
      check("rst_busy", tx_busy, 4'h0);
      check("rst_rd", fifo_rd, 4'h0);
      check("rst_done", tx_done_tick, 4'h0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_tx", tx, 4'hF);
      check("idle_busy", tx_busy, 4'h0);

      // Single byte, no parity.
      push_byte(0, 8'hA5, 1'b1);
      run_frame(1'b0);
      check("single_rd_cnt", rd_cnt[0], 1);
      check("single_done_cnt", done_cnt[0], 1);

      // Back-to-back frames.
      push_byte(0, 8'h00, 1'b1);
      push_byte(0, 8'hFF, 1'b1);
      run_frame(1'b0);
      run_frame(1'b1);
      check("b2b_rd_cnt", rd_cnt[0], 3);

      // Even then odd parity.
      push_byte(1, 8'h07, 1'b1);
      run_frame(1'b0);
      push_byte(2, 8'h07, 1'b1);
      run_frame(1'b0);

      // Two stop bits.
      push_byte(3, 8'h5A, 1'b1);
      run_frame(1'b0);

      // Empty FIFO for 1000 clk.
      bad_tx = 0;
      bad_rd = 0;
      bad_busy = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (tx !== 4'hF) bad_tx++;
         if (fifo_rd !== 4'h0) bad_rd++;
         if (tx_busy !== 4'h0) bad_busy++;
      end
      check("empty_tx_bad", bad_tx, 0);
      check("empty_rd_bad", bad_rd, 0);
      check("empty_busy_bad", bad_busy, 0);

      // Reset during data bit 3, then the next byte goes out cleanly.
      push_byte(0, 8'h3C, 1'b0);
      push_byte(0, 8'h96, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx[0] !== 1'b0 && n < 300);
      check("rmf_start_seen", tx[0], 1'b0);
      a = s_tick ? 1 : 2;
      n = 1;
      while (n < a + 32 * 4 + 15) begin
         @(negedge clk);
         n++;
      end
      check("rmf_busy_before", tx_busy[0], 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("rmf_tx", tx[0], 1'b1);
      check("rmf_busy", tx_busy[0], 1'b0);
      check("rmf_rd", fifo_rd[0], 1'b0);
      check("rmf_rd_cnt", rd_cnt[0], pushed[0] - 1);
      @(negedge clk);
      check("rmf_rd_hold", fifo_rd[0], 1'b0);
      reset = 1'b0;
      run_frame(1'b0);

      for (int i = 0; i < N; i++) begin
         check($sformatf("u%0d_total_rd", i), rd_cnt[i], pushed[i]);
         check($sformatf("u%0d_total_done", i), done_cnt[i], done_exp[i]);
      end
      check("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Transmit side of the UART, and the reader of the transmit FIFO.
- Pops bytes from the FIFO's first-word-fall-through read port (empty/r_data/rd).
- Serializes each byte onto the tx line as start bit, data bits LSB first, optional parity bit, then stop bit(s).
- Bit timing comes from an external 16x-oversampling baud tick. It sits between the TX FIFO and the pad.

Parameters:
- DBIT, 8, data bits per frame (5..8).
- SB_TICK, 16, stop-bit length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tick  input  1  one-clk pulse at 16x baud rate, from the external baud generator.
- fifo_empty  input  1  TX FIFO empty flag.
- fifo_data  input  DBIT  TX FIFO head word; valid whenever fifo_empty=0.
- fifo_rd  output  1  pop strobe to the TX FIFO; exactly one clk per frame.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high whenever the state is not IDLE.
- tx_done_tick  output  1  one-clk pulse on the final tick of the stop bit.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, tick counter=0, bit counter=0, shift register=0.
- Reset mid-frame: on the next edge tx=1 and state=IDLE. The frame is abandoned and no extra pop occurs.
- States and transitions:
  - IDLE -> START: condition is fifo_empty=0. fifo_rd is combinational, (state==IDLE)&~fifo_empty, so it is high for exactly that one clk. On the same edge fifo_data is latched into the shift register, and the parity accumulator is loaded with the XOR of fifo_data.
  - START: tx=0. Count s_tick 0..15. On s_tick with count=15, go to DATA, clear the tick counter, bit counter=0.
  - DATA: tx=shift[0]. On s_tick with count=15: shift right, bit counter+1. When bit counter=DBIT-1, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: tx = XOR(data) for even, ~XOR(data) for odd. Lasts 16 ticks, then STOP.
  - STOP: tx=1 for SB_TICK ticks. On s_tick with count=SB_TICK-1: pulse tx_done_tick and go to IDLE.
- tx timing: tx is registered and changes only on state or bit boundaries (no glitches). With a byte waiting, tx falls on the same edge IDLE->START is taken.
- s_tick handling: ignored in IDLE. The tick counter is cleared on every state entry, so the first bit lasts a full 16 ticks regardless of tick phase.
- Back-to-back frames: the FIFO is non-empty when STOP ends, so exactly one clk is spent in IDLE. That is, the stop bit plus 1 clk, then the next start bit.
- fifo_data after the pop: not sampled again after the pop. FIFO changes during a frame do not affect the frame.
- Counter widths: tick counter 5 bits (covers SB_TICK up to 32). Bit counter $clog2(DBIT) bits. No wrap-around is reachable in legal operation.
- Frame length: 16 + 16*DBIT + 16*(PARITY!=0) + SB_TICK ticks.

Decomposition:
- Package uart_pkg:
  - state encoding IDLE/START/DATA/PARITY/STOP (3 bits);
  - OS=16 oversampling constant;
  - PARITY_NONE/EVEN/ODD codes.
- No sub-module: the counters and shifter stay inline. The baud tick generator (baud_gen) is an existing separate block, instantiated alongside, not inside.

Test Plan:
- Single byte:
  - Stimulus: s_tick every 2 clk, FIFO holding 0xA5, PARITY=0.
  - Response: exactly one fifo_rd pulse. tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 ticks (32 clk). One tx_done_tick at the end. tx_busy falls the clk after the pulse.
- Back-to-back bytes:
  - Stimulus: 0x00 then 0xFF queued.
  - Response: second start bit begins 1 clk after the first frame's stop bit ends. Two fifo_rd pulses total.
- Parity:
  - Stimulus: PARITY=1 with 0x07, then PARITY=2 with 0x07.
  - Response: parity bit 1 (even), then 0 (odd). Each frame is 11 bits.
- Stop length and empty FIFO:
  - Stimulus: SB_TICK=32; FIFO empty for 1000 clk.
  - Response: stop bit lasts 32 ticks. While empty: tx=1, fifo_rd=0, tx_busy=0.
- Reset mid-frame:
  - Stimulus: reset asserted during DATA bit 3.
  - Response: next edge tx=1, tx_busy=0, no fifo_rd. After release, the next queued byte is sent with a full 16-tick start bit.
